fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined datapath. Generalises the earlier two-operand, single-stage forwarding logic to N source operands and M in-flight writer stages. Replaces the start-up cycle counter with per-stage valid tracking and adds a one-cycle interlock for late (shift/memory) results. Sits beside decode: it tracks destination records of instructions in flight, selects each operand from the register file or the youngest matching stage, and stalls decode when a needed result is not yet available.

## Interface
Parameters:
- DATA_W, 8, operand/result width
- REG_AW, 3, register number width
- NUM_SRC, 2, source operands per instruction
- NUM_STAGES, 2, tracked writer stages after decode; must be ≥2
- ZERO_REG, 0, if 1, register 0 is hardwired and never forwarded or stalled on
- SEL_W, $clog2(NUM_STAGES+1), derived width of the select field

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  decode holds a valid instruction
- id_src_reg  in  NUM_SRC*REG_AW  source register numbers; operand i is at [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  operand i is actually read
- id_dst_reg  in  REG_AW  destination register
- id_wr_en  in  1  instruction writes id_dst_reg
- id_late  in  1  result first valid at stage 2 (shift/memory class); otherwise valid at stage 1
- flush  in  1  discard all in-flight records
- rf_data  in  NUM_SRC*DATA_W  register-file read data per operand
- stage_data  in  NUM_STAGES*DATA_W  result bus of stage k (k=1..M) at slot k-1
- stall  out  1  hold decode; the unit inserts a bubble
- fwd_sel  out  NUM_SRC*SEL_W  0 = register file, k = stage k
- opnd_data  out  NUM_SRC*DATA_W  selected operand values
- stall_count  out  16  saturating count of stall cycles

## Operation
- Record per stage k: {valid, dst, late}. Each cycle the records shift: stage k → k+1, and stage M is dropped.
- Stage 1 loads {id_valid & id_wr_en & ~stall, id_dst_reg, id_late}. A stall loads a bubble (valid=0).
- Match for operand i at stage k: id_src_used[i] & valid_k & dst_k==src_i & ~(ZERO_REG & src_i==0).
- Priority: the lowest k wins (youngest writer). No match gives fwd_sel=0 and opnd_data=rf_data slice.
- Hazard: any used operand's winning match is at stage 1 with late=1. Older stages never hide it, because the youngest writer wins.
- FSM states RUN and HOLD.
  - RUN: stall = hazard & id_valid. If stall=1, go to HOLD.
  - HOLD: stall=0. The late record is now at stage 2, so it is forwardable. Go to RUN.
- While stall=1, fwd_sel and opnd_data still show the combinational selection, but they are don't-care to downstream.
- flush, in any state: next cycle all records are invalid and the state is RUN. flush has priority over a record push.
- stall_count increments on every cycle with stall=1 and saturates at 16'hFFFF.

## Timing
- Selection and stall are combinational from records and id_* inputs. There is no added latency.
- Records, FSM state and stall_count update on the rising edge of clk.
- Reset, asynchronous: records invalid, state RUN, stall_count=0. Hence stall=0, fwd_sel=0 and opnd_data=rf_data while reset is held. No warm-up cycles are needed after reset.
- Reset during HOLD returns to RUN immediately. A late record lost to reset is not forwarded.
- A late producer followed directly by a consumer costs exactly 1 stall cycle. The consumer is then served from stage 2.
- Back-to-back writes to the same register: the consumer gets the younger value.
- A stall and flush in the same cycle: flush wins, and the FSM goes to RUN, not HOLD.

## Structure
- Shared package fwd_pkg holds: the FSM state encoding (RUN=1'b0, HOLD=1'b1), the select value FWD_RF=0, and the stall_count width of 16.
- One sub-module, fwd_match, instantiated NUM_SRC times. It does the per-operand priority match across NUM_STAGES records and outputs {sel, late_hit}.
- The top level owns the record shift register, the FSM, the counter and the data muxing.

## Test plan
- Defaults. Reset, then a non-late write to r3, then a read of r3 next cycle: fwd_sel[0]=1, opnd_data=stage_data[0] (e.g. 8'hA5), stall=0.
- Late write to r5, then a read of r5 in operand 1: stall=1 for one cycle, stall_count=1. Next cycle fwd_sel[1]=2, opnd_data=stage_data[1], stall=0.
- Writes r2=8'h11 (stage 2) and r2=8'h22 (stage 1), then a read of r2: fwd_sel=1, value 8'h22.
- ZERO_REG=1. Late write to r0, then a read of r0: stall=0, fwd_sel=0, opnd_data=rf_data.
- Late write to r4, then flush in the hazard cycle: next cycle the r4 read gets fwd_sel=0 and the FSM is in RUN.
- NUM_SRC=3, NUM_STAGES=3: a write to r1 aged to stage 3, then a read of r1 on all three operands: all fwd_sel=3. Assert reset mid-HOLD: stall=0 and stall_count=0 at once.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
//   fsm_state_e  : interlock FSM encoding (RUN, HOLD)
//   FWD_RF       : select value meaning "take the register-file read data"
//   STALL_CNT_W  : width of the saturating stall counter
package fwd_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fsm_state_e;

  localparam int FWD_RF      = 0;
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority match against the in-flight destination records.
// Ports:
//   src_reg     in   source register number of this operand
//   src_used    in   operand is actually read by the instruction in decode
//   rec_valid   in   valid bit of each tracked stage (bit k-1 = stage k)
//   rec_dst     in   destination register of each stage (slot k-1 = stage k)
//   rec_late_s1 in   stage-1 record is a late (shift/memory) result
//   sel         out  0 = register file, k = forward from stage k
//   late_hit    out  winning match is the late record in stage 1
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int NUM_STAGES = 2,
  parameter int ZERO_REG   = 0,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_AW-1:0]            src_reg,
  input  logic                         src_used,
  input  logic [NUM_STAGES-1:0]        rec_valid,
  input  logic [NUM_STAGES*REG_AW-1:0] rec_dst,
  input  logic                         rec_late_s1,
  output logic [SEL_W-1:0]             sel,
  output logic                         late_hit
);

  logic src_zero;

  assign src_zero = (ZERO_REG != 0) && (src_reg == '0);

  // Scan oldest to youngest so the youngest matching writer overwrites sel.
  always_comb begin
    sel = SEL_W'(FWD_RF);
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (src_used && !src_zero && rec_valid[k] &&
          (rec_dst[k*REG_AW +: REG_AW] == src_reg)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

  // Only a stage-1 winner can be unavailable; an older late writer is
  // always shadowed by the stage-1 match when both exist.
  assign late_hit = (sel == SEL_W'(1)) && rec_late_s1;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit sitting beside decode.
// Tracks destination records of instructions in flight, picks every source
// operand from the register file or the youngest matching stage, and stalls
// decode for one cycle when the needed result is a late result still in
// stage 1.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal issue; stall when a used operand hits a late stage-1 record
//   HOLD  | bubble inserted; late record now in stage 2 and forwardable
//
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-high reset
//   id_*          decode-stage instruction: sources, used mask, destination,
//                 write enable, late-result class
//   flush         drop all in-flight records, return to RUN
//   rf_data       register-file read data per operand
//   stage_data    result bus of stage k at slot k-1
//   stall         hold decode this cycle
//   fwd_sel       per-operand select (0 = register file, k = stage k)
//   opnd_data     selected operand values
//   stall_count   saturating count of stall cycles
// NUM_STAGES must be at least 2: the interlock relies on stage 2 existing.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_AW     = 3,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int ZERO_REG   = 0,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]    id_src_reg,
  input  logic [NUM_SRC-1:0]           id_src_used,
  input  logic [REG_AW-1:0]            id_dst_reg,
  input  logic                         id_wr_en,
  input  logic                         id_late,
  input  logic                         flush,
  input  logic [NUM_SRC*DATA_W-1:0]    rf_data,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic                         stall,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]    opnd_data,
  output logic [STALL_CNT_W-1:0]       stall_count
);

  // Older stages only need {valid, dst}: a late result is ready by stage 2,
  // so the late flag is kept for stage 1 alone.
  logic [NUM_STAGES-1:0]        rec_valid_q, rec_valid_d;
  logic [NUM_STAGES*REG_AW-1:0] rec_dst_q, rec_dst_d;
  logic                         rec_late_q, rec_late_d;
  fsm_state_e                   state_q, state_d;
  logic [STALL_CNT_W-1:0]       stall_count_q, stall_count_d;

  logic [NUM_SRC-1:0]           late_hit;
  logic                         hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(
      .REG_AW     (REG_AW),
      .NUM_STAGES (NUM_STAGES),
      .ZERO_REG   (ZERO_REG),
      .SEL_W      (SEL_W)
    ) u_match (
      .src_reg     (id_src_reg[i*REG_AW +: REG_AW]),
      .src_used    (id_src_used[i]),
      .rec_valid   (rec_valid_q),
      .rec_dst     (rec_dst_q),
      .rec_late_s1 (rec_late_q),
      .sel         (fwd_sel[i*SEL_W +: SEL_W]),
      .late_hit    (late_hit[i])
    );
  end

  assign hazard = |late_hit;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = hazard & id_valid;
        if (stall) state_d = ST_HOLD;
      end
      ST_HOLD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    if (flush) state_d = ST_RUN;
  end

  // Record shift: a stalled instruction enters as a bubble.
  always_comb begin
    rec_valid_d = {rec_valid_q[NUM_STAGES-2:0], id_valid & id_wr_en & ~stall};
    rec_dst_d   = {rec_dst_q[(NUM_STAGES-1)*REG_AW-1:0], id_dst_reg};
    rec_late_d  = id_late & id_valid & id_wr_en & ~stall;
    if (flush) begin
      rec_valid_d = '0;
      rec_late_d  = 1'b0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  always_comb begin
    opnd_data = rf_data;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (fwd_sel[i*SEL_W +: SEL_W] == SEL_W'(k + 1)) begin
          opnd_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_valid_q   <= '0;
      rec_dst_q     <= '0;
      rec_late_q    <= 1'b0;
      state_q       <= ST_RUN;
      stall_count_q <= '0;
    end else begin
      rec_valid_q   <= rec_valid_d;
      rec_dst_q     <= rec_dst_d;
      rec_late_q    <= rec_late_d;
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: instance a uses the default
// parameters, instance b uses NUM_SRC=3, NUM_STAGES=3, ZERO_REG=1.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // instance a: defaults
  logic        a_reset, a_id_valid, a_id_wr_en, a_id_late, a_flush;
  logic [5:0]  a_id_src_reg;
  logic [1:0]  a_id_src_used;
  logic [2:0]  a_id_dst_reg;
  logic [15:0] a_rf_data, a_stage_data;
  logic        a_stall;
  logic [3:0]  a_fwd_sel;
  logic [15:0] a_opnd_data;
  logic [15:0] a_stall_count;

  // instance b: three operands, three stages, r0 hardwired
  logic        b_reset, b_id_valid, b_id_wr_en, b_id_late, b_flush;
  logic [8:0]  b_id_src_reg;
  logic [2:0]  b_id_src_used;
  logic [2:0]  b_id_dst_reg;
  logic [23:0] b_rf_data, b_stage_data;
  logic        b_stall;
  logic [5:0]  b_fwd_sel;
  logic [23:0] b_opnd_data;
  logic [15:0] b_stall_count;

  fwd_hazard_unit dut_a (
    .clk         (clk),
    .reset       (a_reset),
    .id_valid    (a_id_valid),
    .id_src_reg  (a_id_src_reg),
    .id_src_used (a_id_src_used),
    .id_dst_reg  (a_id_dst_reg),
    .id_wr_en    (a_id_wr_en),
    .id_late     (a_id_late),
    .flush       (a_flush),
    .rf_data     (a_rf_data),
    .stage_data  (a_stage_data),
    .stall       (a_stall),
    .fwd_sel     (a_fwd_sel),
    .opnd_data   (a_opnd_data),
    .stall_count (a_stall_count)
  );

  fwd_hazard_unit #(
    .NUM_SRC    (3),
    .NUM_STAGES (3),
    .ZERO_REG   (1)
  ) dut_b (
    .clk         (clk),
    .reset       (b_reset),
    .id_valid    (b_id_valid),
    .id_src_reg  (b_id_src_reg),
    .id_src_used (b_id_src_used),
    .id_dst_reg  (b_id_dst_reg),
    .id_wr_en    (b_id_wr_en),
    .id_late     (b_id_late),
    .flush       (b_flush),
    .rf_data     (b_rf_data),
    .stage_data  (b_stage_data),
    .stall       (b_stall),
    .fwd_sel     (b_fwd_sel),
    .opnd_data   (b_opnd_data),
    .stall_count (b_stall_count)
  );

  typedef struct {
    string       tag;
    logic        stall;
    logic [7:0]  sel;
    logic [23:0] opnd;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
  endtask

  task automatic push_exp(input string tag, input logic st, input logic [7:0] sel,
                          input logic [23:0] opnd, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.stall = st; e.sel = sel; e.opnd = opnd; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic cmp_a();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard_a: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("%s.stall", e.tag), 32'(a_stall),       32'(e.stall));
    chk($sformatf("%s.sel",   e.tag), 32'(a_fwd_sel),     32'(e.sel));
    chk($sformatf("%s.opnd",  e.tag), 32'(a_opnd_data),   32'(e.opnd));
    chk($sformatf("%s.cnt",   e.tag), 32'(a_stall_count), 32'(e.cnt));
  endtask

  task automatic cmp_b();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard_b: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("%s.stall", e.tag), 32'(b_stall),       32'(e.stall));
    chk($sformatf("%s.sel",   e.tag), 32'(b_fwd_sel),     32'(e.sel));
    chk($sformatf("%s.opnd",  e.tag), 32'(b_opnd_data),   32'(e.opnd));
    chk($sformatf("%s.cnt",   e.tag), 32'(b_stall_count), 32'(e.cnt));
  endtask

  task automatic step_a();
    @(negedge clk);
    cmp_a();
    @(posedge clk);
    #1;
  endtask

  task automatic step_b();
    @(negedge clk);
    cmp_b();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic vld, input logic wr, input logic [2:0] dst,
                         input logic late, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] used, input logic fl);
    a_id_valid = vld; a_id_wr_en = wr; a_id_dst_reg = dst; a_id_late = late;
    a_id_src_reg = {s1, s0}; a_id_src_used = used; a_flush = fl;
  endtask

  task automatic drive_b(input logic vld, input logic wr, input logic [2:0] dst,
                         input logic late, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] used, input logic fl);
    b_id_valid = vld; b_id_wr_en = wr; b_id_dst_reg = dst; b_id_late = late;
    b_id_src_reg = {s2, s1, s0}; b_id_src_used = used; b_flush = fl;
  endtask

  localparam logic [23:0] A_RF = 24'h00F1F0;
  localparam logic [23:0] B_RF = 24'hC2C1C0;

  initial begin
    a_reset = 1'b1;
    b_reset = 1'b1;
    a_rf_data    = 16'hF1F0;
    a_stage_data = 16'h5AA5;   // stage 1 = A5, stage 2 = 5A
    b_rf_data    = 24'hC2C1C0;
    b_stage_data = 24'hB3B2B1; // stage k = Bk
    drive_a(1, 0, 0, 0, 3, 3, 2'b11, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);

    // ---------------- instance a ----------------
    push_exp("a_rst", 0, 8'h00, A_RF, 0);                     step_a();
    a_reset = 1'b0;

    drive_a(1, 1, 3, 0, 0, 0, 2'b00, 0);
    push_exp("a_wr_r3", 0, 8'h00, A_RF, 0);                   step_a();
    drive_a(1, 0, 0, 0, 3, 0, 2'b01, 0);
    push_exp("a_rd_r3", 0, 8'h01, 24'h00F1A5, 0);             step_a();

    drive_a(1, 1, 5, 1, 0, 0, 2'b00, 0);
    push_exp("a_wr_r5_late", 0, 8'h00, A_RF, 0);              step_a();
    drive_a(1, 0, 0, 0, 0, 5, 2'b10, 0);
    push_exp("a_rd_r5_stall", 1, 8'h04, 24'h00A5F0, 0);       step_a();
    push_exp("a_rd_r5_fwd", 0, 8'h08, 24'h005AF0, 1);         step_a();

    a_stage_data = 16'h1122;   // stage 1 = 22 (younger), stage 2 = 11
    drive_a(1, 1, 2, 0, 0, 0, 2'b00, 0);
    push_exp("a_wr_r2_old", 0, 8'h00, A_RF, 1);               step_a();
    push_exp("a_wr_r2_new", 0, 8'h00, A_RF, 1);               step_a();
    drive_a(1, 0, 0, 0, 2, 2, 2'b11, 0);
    push_exp("a_rd_r2_young", 0, 8'h05, 24'h002222, 1);       step_a();
    a_stage_data = 16'h5AA5;

    drive_a(1, 1, 4, 1, 0, 0, 2'b00, 0);
    push_exp("a_wr_r4_late", 0, 8'h00, A_RF, 1);              step_a();
    drive_a(1, 0, 0, 0, 4, 0, 2'b01, 1);
    push_exp("a_flush_hazard", 1, 8'h01, 24'h00F1A5, 1);      step_a();
    drive_a(1, 0, 0, 0, 4, 0, 2'b01, 0);
    push_exp("a_after_flush", 0, 8'h00, A_RF, 2);             step_a();

    drive_a(1, 1, 1, 0, 0, 0, 2'b00, 1);
    push_exp("a_flush_push", 0, 8'h00, A_RF, 2);              step_a();
    drive_a(1, 0, 0, 0, 1, 0, 2'b01, 0);
    push_exp("a_after_flush_push", 0, 8'h00, A_RF, 2);        step_a();

    drive_a(1, 1, 7, 1, 0, 0, 2'b00, 0);
    push_exp("a_wr_r7_late", 0, 8'h00, A_RF, 2);              step_a();
    drive_a(1, 0, 0, 0, 7, 7, 2'b00, 0);
    push_exp("a_rd_r7_unused", 0, 8'h00, A_RF, 2);            step_a();

    drive_a(1, 1, 6, 1, 0, 0, 2'b00, 0);
    push_exp("a_wr_r6_late", 0, 8'h00, A_RF, 2);              step_a();
    drive_a(0, 0, 0, 0, 6, 0, 2'b01, 0);
    push_exp("a_rd_r6_noid", 0, 8'h01, 24'h00F1A5, 2);        step_a();

    // ---------------- instance b ----------------
    drive_b(1, 0, 0, 0, 1, 1, 1, 3'b111, 0);
    push_exp("b_rst", 0, 8'h00, B_RF, 0);                     step_b();
    b_reset = 1'b0;

    drive_b(1, 1, 0, 1, 0, 0, 0, 3'b000, 0);
    push_exp("b_wr_r0_late", 0, 8'h00, B_RF, 0);              step_b();
    drive_b(1, 0, 0, 0, 0, 0, 0, 3'b001, 0);
    push_exp("b_rd_r0", 0, 8'h00, B_RF, 0);                   step_b();

    drive_b(1, 1, 1, 0, 0, 0, 0, 3'b000, 0);
    push_exp("b_wr_r1", 0, 8'h00, B_RF, 0);                   step_b();
    drive_b(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    push_exp("b_idle1", 0, 8'h00, B_RF, 0);                   step_b();
    push_exp("b_idle2", 0, 8'h00, B_RF, 0);                   step_b();
    drive_b(1, 0, 0, 0, 1, 1, 1, 3'b111, 0);
    push_exp("b_rd_r1_s3", 0, 8'h3F, 24'hB3B3B3, 0);          step_b();

    drive_b(1, 1, 6, 1, 0, 0, 0, 3'b000, 0);
    push_exp("b_wr_r6_late", 0, 8'h00, B_RF, 0);              step_b();
    drive_b(1, 0, 0, 0, 0, 0, 6, 3'b100, 0);
    push_exp("b_rd_r6_stall", 1, 8'h10, 24'hB1C1C0, 0);       step_b();

    // now one time unit into the HOLD cycle
    push_exp("b_hold", 0, 8'h20, 24'hB2C1C0, 1);
    cmp_b();
    #1 b_reset = 1'b1;
    #1;
    push_exp("b_rst_in_hold", 0, 8'h00, B_RF, 0);
    cmp_b();
    #1 b_reset = 1'b0;
    push_exp("b_after_rst", 0, 8'h00, B_RF, 0);               step_b();

    drive_b(1, 1, 6, 1, 0, 0, 0, 3'b000, 0);
    push_exp("b_wr_r6_late2", 0, 8'h00, B_RF, 0);             step_b();
    drive_b(1, 0, 0, 0, 0, 0, 6, 3'b100, 0);
    push_exp("b_rd_r6_stall2", 1, 8'h10, 24'hB1C1C0, 0);      step_b();
    push_exp("b_hold2", 0, 8'h20, 24'hB2C1C0, 1);             step_b();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
